// File: rtl/dna_pkg.sv
// dna_pkg: shared state encoding and constants for the device-DNA reader
package dna_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} dna_state_e;
    localparam int DNA_WIDTH_7SERIES = 57;
    localparam int DNA_MAX_CLK_HZ    = 2_000_000;
endpackage

// File: rtl/dna_clk_div.sv
// dna_clk_div: free-running divider producing the primitive clock and edge ticks
// clk, reset_n : system clock, async active-low reset
// dna_clk      : registered divided clock, period 2*CLK_DIV clk cycles
// rise_tick    : high in the clk cycle whose edge takes dna_clk 0->1
// fall_tick    : high in the clk cycle whose edge takes dna_clk 1->0
module dna_clk_div
    import dna_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset_n,
    output logic dna_clk,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] cnt;
    logic          tc;
    assign tc        = cnt == CW'(CLK_DIV - 1);
    assign rise_tick = tc & ~dna_clk;
    assign fall_tick = tc & dna_clk;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            dna_clk <= 1'b0;
        end else begin
            cnt     <= tc ? '0 : cnt + CW'(1);
            dna_clk <= dna_clk ^ tc;
        end
    end
endmodule

// File: rtl/dna_reader.sv
// dna_reader: reads a DNA_PORT-style serial ID MSB-first and publishes it atomically
// clk, reset_n        : system clock, async active-low reset
// start               : request a (re)read, ignored while busy
// busy, done          : read in progress / one-clk publish pulse
// id_valid, id        : published ID, MSB is the first bit shifted out
// dna_clk, dna_read, dna_shift, dna_din, dna_dout : primitive interface
module dna_reader
    import dna_pkg::*;
#(
    parameter int ID_WIDTH   = DNA_WIDTH_7SERIES,
    parameter int CLK_DIV    = 16,
    parameter bit AUTO_START = 1'b1,
    parameter bit ROTATE     = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                id_valid,
    output logic [ID_WIDTH-1:0] id,
    output logic                dna_clk,
    output logic                dna_read,
    output logic                dna_shift,
    output logic                dna_din,
    input  logic                dna_dout
);
    localparam int CW = $clog2(ID_WIDTH + 1);
    dna_state_e          state, state_n;
    logic                rise_tick, fall_tick;
    logic                req, req_n, read_n, shift_n, busy_n, done_n, valid_n, din_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [ID_WIDTH-1:0] shreg, shreg_n, id_n, shifted;

    dna_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .dna_clk   (dna_clk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign shifted = (shreg << 1) | ID_WIDTH'(dna_dout);

    // The last capture publishes in the same cycle so the primitive never sees an extra shift edge
    always_comb begin
        state_n = state;
        req_n   = req | (start & ~busy);
        read_n  = dna_read;
        shift_n = dna_shift;
        busy_n  = busy;
        done_n  = 1'b0;
        valid_n = id_valid;
        id_n    = id;
        shreg_n = shreg;
        cnt_n   = cnt;
        din_n   = (ROTATE && fall_tick) ? dna_dout : dna_din;
        case (state)
            IDLE, DONE: if (fall_tick && req) begin
                state_n = LOAD;
                read_n  = 1'b1;
                busy_n  = 1'b1;
                req_n   = 1'b0;
            end
            LOAD: if (fall_tick) begin
                state_n = SHIFT;
                read_n  = 1'b0;
                shift_n = 1'b1;
                cnt_n   = '0;
            end
            SHIFT: if (rise_tick) begin
                shreg_n = shifted;
                cnt_n   = cnt + CW'(1);
                if (cnt == CW'(ID_WIDTH - 1)) begin
                    state_n = DONE;
                    shift_n = 1'b0;
                    id_n    = shifted;
                    valid_n = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req       <= AUTO_START;
            dna_read  <= 1'b0;
            dna_shift <= 1'b0;
            dna_din   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            id_valid  <= 1'b0;
            id        <= '0;
            shreg     <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            req       <= req_n;
            dna_read  <= read_n;
            dna_shift <= shift_n;
            dna_din   <= din_n;
            busy      <= busy_n;
            done      <= done_n;
            id_valid  <= valid_n;
            id        <= id_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
        end
    end
endmodule

// File: tb/tb_dna_reader.sv
// tb_dna_reader: scoreboard bench for dna_reader across three parameter sets
module tb_dna_reader;
    localparam logic [56:0] V_A = 57'h1_2345_6789_ABCD_EF;
    localparam logic [56:0] V_C = 57'hAA_AAAA_AAAA_AAAA;
    localparam logic [7:0]  V_B = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a = 1'b1, rst_bc = 1'b1;
    logic [2:0] st = '0;
    logic [2:0] bsy, dn, vld, dclk, drd, dsh, ddin, ddout;
    logic [56:0] id_a, id_c;
    logic [7:0]  id_b;

    logic [63:0] mval [3];
    bit          reload [3];
    logic [63:0] exp_q [$];
    int pass = 0, total = 0;
    int n_done0 = 0, n_done1 = 0, n_done2 = 0;
    int busy_viol = 0, din_bad = 0, glitch_c = 0;
    logic prev_b = 1'b0;
    logic [56:0] last_c = '0;
    logic last_vc = 1'b0;

    dna_reader #(.ID_WIDTH(57), .CLK_DIV(2), .AUTO_START(1'b1), .ROTATE(1'b0)) u_a (
        .clk(clk), .reset_n(rst_a), .start(st[0]), .busy(bsy[0]), .done(dn[0]),
        .id_valid(vld[0]), .id(id_a), .dna_clk(dclk[0]), .dna_read(drd[0]),
        .dna_shift(dsh[0]), .dna_din(ddin[0]), .dna_dout(ddout[0]));
    dna_reader #(.ID_WIDTH(8), .CLK_DIV(5), .AUTO_START(1'b0), .ROTATE(1'b0)) u_b (
        .clk(clk), .reset_n(rst_bc), .start(st[1]), .busy(bsy[1]), .done(dn[1]),
        .id_valid(vld[1]), .id(id_b), .dna_clk(dclk[1]), .dna_read(drd[1]),
        .dna_shift(dsh[1]), .dna_din(ddin[1]), .dna_dout(ddout[1]));
    dna_reader #(.ID_WIDTH(57), .CLK_DIV(2), .AUTO_START(1'b0), .ROTATE(1'b1)) u_c (
        .clk(clk), .reset_n(rst_bc), .start(st[2]), .busy(bsy[2]), .done(dn[2]),
        .id_valid(vld[2]), .id(id_c), .dna_clk(dclk[2]), .dna_read(drd[2]),
        .dna_shift(dsh[2]), .dna_din(ddin[2]), .dna_dout(ddout[2]));

    // Behavioural primitive: controls sampled at the preceding negedge model setup before the dna_clk rise
    for (genvar g = 0; g < 3; g++) begin : m
        localparam int MW = (g == 1) ? 8 : 57;
        logic [63:0] mreg = '0;
        int n_read = 0, n_shift = 0;
        logic r_s = 1'b0, s_s = 1'b0, d_s = 1'b0;
        always @(negedge clk) begin
            r_s <= drd[g];
            s_s <= dsh[g];
            d_s <= ddin[g];
        end
        always @(posedge dclk[g]) begin
            if (r_s) begin
                if (reload[g]) mreg <= mval[g];
                n_read <= n_read + 1;
            end else if (s_s) begin
                mreg    <= ((mreg << 1) | 64'(d_s)) & ((64'd1 << MW) - 64'd1);
                n_shift <= n_shift + 1;
            end
        end
        assign ddout[g] = mreg[MW-1];
    end

    always @(negedge clk) begin
        n_done0 <= n_done0 + int'(dn[0]);
        n_done1 <= n_done1 + int'(dn[1]);
        n_done2 <= n_done2 + int'(dn[2]);
        prev_b  <= bsy[0];
        if (rst_a && prev_b && !bsy[0] && !dn[0]) busy_viol <= busy_viol + 1;
        if (ddin[0] || ddin[1]) din_bad <= din_bad + 1;
        if (rst_bc && !dn[2] && (id_c !== last_c || vld[2] !== last_vc)) glitch_c <= glitch_c + 1;
        last_c  <= id_c;
        last_vc <= vld[2];
    end

    task automatic pulse(input int i);
        @(negedge clk);
        st[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, output int cyc);
        cyc = 0;
        while (dn[i] !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        #2;
        rst_a  = 1'b0;
        rst_bc = 1'b0;
        #1;
        total++;
        if ({bsy, dn, vld, dclk, drd, dsh} !== 18'b0) $display("FAIL reset_ctrl got %b want 0", {bsy, dn, vld, dclk, drd, dsh});
        else pass++;
        total++;
        if ({id_a, id_b, id_c} !== 122'b0) $display("FAIL reset_id got %h/%h/%h want 0", id_a, id_b, id_c);
        else pass++;
        repeat (3) @(negedge clk);
        rst_a  = 1'b1;
        rst_bc = 1'b1;
        exp_q.push_back(64'(V_A));
    endtask

    task automatic test_auto_read;
        int cyc;
        logic [63:0] e;
        wait_done(0, 400, cyc);
        total++;
        if (dn[0] !== 1'b1) $display("FAIL auto_done timeout after %0d cycles", cyc);
        else pass++;
        e = exp_q.pop_front();
        total++;
        if (id_a !== e[56:0] || vld[0] !== 1'b1) $display("FAIL auto_id got %h v%b want %h v1", id_a, vld[0], e[56:0]);
        else pass++;
        @(negedge clk);
        total++;
        if (n_done0 !== 1 || m[0].n_shift !== 57 || m[0].n_read !== 1)
            $display("FAIL auto_counts got done=%0d shifts=%0d reads=%0d want 1/57/1", n_done0, m[0].n_shift, m[0].n_read);
        else pass++;
        total++;
        if (bsy[2:1] !== 2'b0 || vld[2:1] !== 2'b0 || dn[0] !== 1'b0)
            $display("FAIL idle_others got busy=%b valid=%b done=%b want 0", bsy[2:1], vld[2:1], dn[0]);
        else pass++;
    endtask

    task automatic test_width_div;
        int c, per, cyc;
        logic [63:0] e;
        c = 0;
        while (dclk[1] !== 1'b0 && c < 100) begin @(negedge clk); c++; end
        while (dclk[1] !== 1'b1 && c < 100) begin @(negedge clk); c++; end
        per = 0;
        while (dclk[1] !== 1'b0 && per < 100) begin @(negedge clk); per++; end
        while (dclk[1] !== 1'b1 && per < 100) begin @(negedge clk); per++; end
        total++;
        if (per !== 10) $display("FAIL div_period got %0d want 10", per);
        else pass++;
        exp_q.push_back(64'(V_B));
        pulse(1);
        wait_done(1, 200, cyc);
        total++;
        if (dn[1] !== 1'b1 || cyc + 1 > 110) $display("FAIL div_latency got %0d cycles done=%b want <=110", cyc + 1, dn[1]);
        else pass++;
        e = exp_q.pop_front();
        total++;
        if (id_b !== e[7:0] || vld[1] !== 1'b1) $display("FAIL div_id got %h v%b want %h v1", id_b, vld[1], e[7:0]);
        else pass++;
        @(negedge clk);
    endtask

    task automatic test_destructive;
        int cyc;
        logic [63:0] e;
        total++;
        if (m[0].mreg !== 64'd0) $display("FAIL destr_reg got %h want 0", m[0].mreg);
        else pass++;
        reload[0] = 1'b0;
        exp_q.push_back(64'd0);
        pulse(0);
        wait_done(0, 400, cyc);
        e = exp_q.pop_front();
        total++;
        if (dn[0] !== 1'b1 || id_a !== e[56:0]) $display("FAIL destr_zero got %h done=%b want %h", id_a, dn[0], e[56:0]);
        else pass++;
        @(negedge clk);
        reload[0] = 1'b1;
        exp_q.push_back(64'(V_A));
        pulse(0);
        wait_done(0, 400, cyc);
        e = exp_q.pop_front();
        total++;
        if (dn[0] !== 1'b1 || id_a !== e[56:0]) $display("FAIL destr_reload got %h done=%b want %h", id_a, dn[0], e[56:0]);
        else pass++;
        @(negedge clk);
        total++;
        if (din_bad !== 0) $display("FAIL destr_din got %0d nonzero cycles want 0", din_bad);
        else pass++;
    endtask

    task automatic test_busy_guard;
        int cyc, base_r, base_d, base_s;
        logic [63:0] e;
        base_r = m[0].n_read;
        base_d = n_done0;
        base_s = m[0].n_shift;
        exp_q.push_back(64'(V_A));
        pulse(0);
        cyc = 0;
        while (m[0].n_shift < base_s + 10 && cyc < 300) begin @(negedge clk); cyc++; end
        for (int k = 0; k < 3; k++) begin
            pulse(0);
            repeat (3) @(negedge clk);
        end
        wait_done(0, 400, cyc);
        e = exp_q.pop_front();
        total++;
        if (dn[0] !== 1'b1 || id_a !== e[56:0]) $display("FAIL guard_id got %h done=%b want %h", id_a, dn[0], e[56:0]);
        else pass++;
        repeat (30) @(negedge clk);
        total++;
        if (m[0].n_read !== base_r + 1 || n_done0 !== base_d + 1 || bsy[0] !== 1'b0)
            $display("FAIL guard_once got reads=%0d dones=%0d busy=%b want %0d/%0d/0",
                     m[0].n_read - base_r, n_done0 - base_d, bsy[0], 1, 1);
        else pass++;
        total++;
        if (busy_viol !== 0) $display("FAIL guard_busy got %0d early busy drops want 0", busy_viol);
        else pass++;
    endtask

    task automatic test_rotate;
        int cyc;
        logic [63:0] e;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(64'(V_C));
            pulse(2);
            wait_done(2, 400, cyc);
            e = exp_q.pop_front();
            total++;
            if (dn[2] !== 1'b1 || id_c !== e[56:0] || vld[2] !== 1'b1)
                $display("FAIL rot_id%0d got %h v%b want %h v1", r, id_c, vld[2], e[56:0]);
            else pass++;
            @(negedge clk);
            total++;
            if (m[2].mreg !== 64'(V_C)) $display("FAIL rot_restore%0d got %h want %h", r, m[2].mreg, 64'(V_C));
            else pass++;
        end
        total++;
        if (glitch_c !== 0) $display("FAIL rot_stable got %0d id changes outside done want 0", glitch_c);
        else pass++;
    endtask

    task automatic test_reset_mid;
        int cyc, base_s;
        logic [63:0] e;
        base_s = m[0].n_shift;
        pulse(0);
        cyc = 0;
        while (m[0].n_shift < base_s + 20 && cyc < 300) begin @(negedge clk); cyc++; end
        total++;
        if (bsy[0] !== 1'b1 || dsh[0] !== 1'b1) $display("FAIL mid_active got busy=%b shift=%b want 1/1", bsy[0], dsh[0]);
        else pass++;
        #2;
        rst_a = 1'b0;
        #1;
        total++;
        if ({bsy[0], dn[0], vld[0], dclk[0], drd[0], dsh[0], ddin[0]} !== 7'b0 || id_a !== 57'b0)
            $display("FAIL mid_reset got ctrl=%b id=%h want 0", {bsy[0], dn[0], vld[0], dclk[0], drd[0], dsh[0], ddin[0]}, id_a);
        else pass++;
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        exp_q.push_back(64'(V_A));
        wait_done(0, 400, cyc);
        e = exp_q.pop_front();
        total++;
        if (dn[0] !== 1'b1 || id_a !== e[56:0] || vld[0] !== 1'b1)
            $display("FAIL mid_reread got %h v%b done=%b want %h v1", id_a, vld[0], dn[0], e[56:0]);
        else pass++;
        @(negedge clk);
    endtask

    initial begin
        mval[0] = 64'(V_A);
        mval[1] = 64'(V_B);
        mval[2] = 64'(V_C);
        for (int i = 0; i < 3; i++) reload[i] = 1'b1;
        test_reset;
        test_auto_read;
        test_width_div;
        test_destructive;
        test_busy_guard;
        test_rotate;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
